// File: rtl/sram_phase_ctrl_if.sv
// Request-side handshake between a memory client (self-test or CPU path) and
// the SRAM phase sequencer.
interface sram_phase_ctrl_if #(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic              busy;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, busy, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, busy, rdata
   );
endinterface

// File: rtl/sram_phase_ctrl.sv
// Single-port access engine for the 512k x 32 asynchronous SRAM: turns a one-cycle
// request into setup / strobe / hold phases with all pin outputs registered.
module sram_phase_ctrl #(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 1,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic              fastclk,
   input  logic              rst,
   sram_phase_ctrl_if.slave  bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              ram_wr,
   output logic              ram_oe,
   output logic              ram_cs,
   output logic              ram_ub_b,
   output logic              ram_lb_b
);

   if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
       HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
      $error("sram_phase_ctrl: SETUP_CYC, STROBE_CYC and HOLD_CYC must be 1..15");
   end

   localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              oe_q, oe_d;
   logic              cs_q, cs_d;
   logic              doe_q, doe_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      oe_d    = oe_q;
      cs_d    = cs_q;
      doe_d   = doe_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               state_d = StSetup;
               cnt_d   = SetupLd;
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
               doe_d   = bus.we;
            end
         end
         StSetup: begin
            if (cnt_q == 4'd0) begin
               state_d = StStrobe;
               cnt_d   = StrobeLd;
               wr_d    = ~we_q;
               oe_d    = we_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StStrobe: begin
            if (cnt_q == 4'd0) begin
               state_d = StHold;
               cnt_d   = HoldLd;
               wr_d    = 1'b1;
               oe_d    = 1'b1;
               // OE is still low up to this edge, so the pins carry valid read data.
               if (!we_q) begin
                  rdata_d = ram_data_in;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               cs_d    = 1'b1;
               doe_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge fastclk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b1;
         oe_q    <= 1'b1;
         cs_q    <= 1'b1;
         doe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         oe_q    <= oe_d;
         cs_q    <= cs_d;
         doe_q   <= doe_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.busy     = busy_q;
   assign bus.rdata    = rdata_q;
   assign ram_addr     = addr_q;
   assign ram_data_out = wdata_q;
   assign ram_data_oe  = doe_q;
   assign ram_wr       = wr_q;
   assign ram_oe       = oe_q;
   // Both byte lanes are always enabled together with the chip select.
   assign ram_cs       = cs_q;
   assign ram_ub_b     = cs_q;
   assign ram_lb_b     = cs_q;

endmodule

// File: tb/tb_sram_phase_ctrl.sv
// Bench for sram_phase_ctrl: one default-timing instance and one with
// SETUP=2/STROBE=3/HOLD=1, each wired to a behavioural asynchronous SRAM.
module tb_sram_phase_ctrl;
   localparam int unsigned AW = 19;
   localparam int unsigned DW = 32;

   logic fastclk = 1'b0;
   always #5 fastclk = ~fastclk;

   logic          rst     [2];
   logic          req_v   [2];
   logic          we_v    [2];
   logic [AW-1:0] addr_v  [2];
   logic [DW-1:0] wdata_v [2];
   logic          ack_w   [2];
   logic          busy_w  [2];
   logic [DW-1:0] rdata_w [2];
   logic [AW-1:0] ram_addr [2];
   logic [DW-1:0] dout [2];
   logic [DW-1:0] din  [2];
   logic          doe [2];
   logic          wr  [2];
   logic          oe  [2];
   logic          cs  [2];
   logic          ub  [2];
   logic          lb  [2];

   sram_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   sram_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.req   = req_v[0];
   assign bus0.we    = we_v[0];
   assign bus0.addr  = addr_v[0];
   assign bus0.wdata = wdata_v[0];
   assign ack_w[0]   = bus0.ack;
   assign busy_w[0]  = bus0.busy;
   assign rdata_w[0] = bus0.rdata;
   assign bus1.req   = req_v[1];
   assign bus1.we    = we_v[1];
   assign bus1.addr  = addr_v[1];
   assign bus1.wdata = wdata_v[1];
   assign ack_w[1]   = bus1.ack;
   assign busy_w[1]  = bus1.busy;
   assign rdata_w[1] = bus1.rdata;

   sram_phase_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
   ) u_dut0 (
      .fastclk(fastclk), .rst(rst[0]), .bus(bus0),
      .ram_addr(ram_addr[0]), .ram_data_out(dout[0]), .ram_data_oe(doe[0]),
      .ram_data_in(din[0]), .ram_wr(wr[0]), .ram_oe(oe[0]), .ram_cs(cs[0]),
      .ram_ub_b(ub[0]), .ram_lb_b(lb[0])
   );

   sram_phase_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)
   ) u_dut1 (
      .fastclk(fastclk), .rst(rst[1]), .bus(bus1),
      .ram_addr(ram_addr[1]), .ram_data_out(dout[1]), .ram_data_oe(doe[1]),
      .ram_data_in(din[1]), .ram_wr(wr[1]), .ram_oe(oe[1]), .ram_cs(cs[1]),
      .ram_ub_b(ub[1]), .ram_lb_b(lb[1])
   );

   // Power-up contents; puts 0x12345678 at the top word 0x7FFFF.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return 32'h1234_5678 ^ {13'd0, a ^ 19'h7FFFF};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_sram
      logic [DW-1:0] mem [0:(1<<AW)-1];
      bit            wrt [0:(1<<AW)-1];
      int            overlap = 0;
      int            nodrive = 0;

      assign din[g] = (!cs[g] && !oe[g]) ?
                      (wrt[ram_addr[g]] ? mem[ram_addr[g]] : init_val(ram_addr[g])) :
                      32'hBAD0_BAD0;

      always @(negedge fastclk) begin
         if (!cs[g] && !wr[g]) begin
            mem[ram_addr[g]] <= dout[g];
            wrt[ram_addr[g]] <= 1'b1;
         end
         if (!wr[g] && !oe[g]) overlap <= overlap + 1;
         if (!wr[g] && !doe[g]) nodrive <= nodrive + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] exp_rdata [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int s_of(input int s); return (s == 0) ? 1 : 2; endfunction
   function automatic int t_of(input int s); return (s == 0) ? 1 : 3; endfunction
   function automatic int h_of(input int s); return 1; endfunction

   function automatic int key(input int s, input logic [AW-1:0] a);
      return s * (1 << 20) + int'({13'd0, a});
   endfunction

   function automatic logic [DW-1:0] ref_rd(input int s, input logic [AW-1:0] a);
      if (ref_mem.exists(key(s, a))) return ref_mem[key(s, a)];
      return init_val(a);
   endfunction

   function automatic string tg(input int s, input string n);
      return $sformatf("d%0d_%s", s, n);
   endfunction

   task automatic reset_check(input int s);
      rst[s] = 1'b1;
      @(posedge fastclk);
      @(negedge fastclk);
      check_eq(tg(s, "rst_wr"), 64'(wr[s]), 64'd1);
      check_eq(tg(s, "rst_oe"), 64'(oe[s]), 64'd1);
      check_eq(tg(s, "rst_cs"), 64'(cs[s]), 64'd1);
      check_eq(tg(s, "rst_ub"), 64'(ub[s]), 64'd1);
      check_eq(tg(s, "rst_lb"), 64'(lb[s]), 64'd1);
      check_eq(tg(s, "rst_doe"), 64'(doe[s]), 64'd0);
      check_eq(tg(s, "rst_ack"), 64'(ack_w[s]), 64'd0);
      check_eq(tg(s, "rst_busy"), 64'(busy_w[s]), 64'd0);
      check_eq(tg(s, "rst_rdata"), 64'(rdata_w[s]), 64'd0);
      check_eq(tg(s, "rst_addr"), 64'(ram_addr[s]), 64'd0);
      check_eq(tg(s, "rst_dout"), 64'(dout[s]), 64'd0);
      rst[s] = 1'b0;
      exp_rdata[s] = '0;
   endtask

   // One access; poke raises a stray req to addr 0x2 while the engine is busy.
   task automatic access(input int s, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit poke);
      int sc = s_of(s);
      int tc = t_of(s);
      int l  = s_of(s) + t_of(s) + h_of(s);
      int wr_n = 0, wr_f = -1, oe_n = 0, oe_f = -1, doe_n = 0, doe_f = -1;
      int cs_n = 0, busy_n = 0, ack_n = 0, ack_f = -1, addr_bad = 0, dout_bad = 0;
      logic [DW-1:0] rd_at_ack = '0;
      @(posedge fastclk);
      #1;
      req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
      @(posedge fastclk);
      #1;
      req_v[s] = poke;
      if (poke) addr_v[s] = 19'h00002;
      for (int j = 0; j < l + 3; j++) begin
         @(negedge fastclk);
         if (!wr[s]) begin wr_n++; if (wr_f < 0) wr_f = j; end
         if (!oe[s]) begin oe_n++; if (oe_f < 0) oe_f = j; end
         if (doe[s]) begin doe_n++; if (doe_f < 0) doe_f = j; end
         if (!cs[s] && !ub[s] && !lb[s]) cs_n++;
         if (busy_w[s]) busy_n++;
         if (ack_w[s]) begin
            ack_n++;
            if (ack_f < 0) begin ack_f = j; rd_at_ack = rdata_w[s]; end
         end
         if (ram_addr[s] != a) addr_bad++;
         if (w && j < l && dout[s] != d) dout_bad++;
         if (j == 1) req_v[s] = 1'b0;
      end
      if (w) ref_mem[key(s, a)] = d;
      else exp_rdata[s] = ref_rd(s, a);
      check_eq(tg(s, "wr_low_cycles"), 64'(wr_n), 64'(w ? tc : 0));
      check_eq(tg(s, "wr_low_first"), 64'(wr_f), 64'(w ? sc : -1));
      check_eq(tg(s, "oe_low_cycles"), 64'(oe_n), 64'(w ? 0 : tc));
      check_eq(tg(s, "oe_low_first"), 64'(oe_f), 64'(w ? -1 : sc));
      check_eq(tg(s, "data_oe_cycles"), 64'(doe_n), 64'(w ? l : 0));
      check_eq(tg(s, "data_oe_first"), 64'(doe_f), 64'(w ? 0 : -1));
      check_eq(tg(s, "cs_low_cycles"), 64'(cs_n), 64'(l));
      check_eq(tg(s, "busy_cycles"), 64'(busy_n), 64'(l));
      check_eq(tg(s, "ack_count"), 64'(ack_n), 64'd1);
      check_eq(tg(s, "ack_latency"), 64'(ack_f), 64'(l));
      check_eq(tg(s, "addr_stable"), 64'(addr_bad), 64'd0);
      if (w) check_eq(tg(s, "wdata_stable"), 64'(dout_bad), 64'd0);
      check_eq(tg(s, "rdata_at_ack"), 64'(rd_at_ack), 64'(exp_rdata[s]));
   endtask

   task automatic back_to_back();
      int cyc = 0, last = -1, acks = 0;
      bit cur_we = 1'b1;
      @(posedge fastclk);
      #1;
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 19'h00001; wdata_v[0] = 32'hA5A5_A5A5;
      while (acks < 4 && cyc < 40) begin
         @(negedge fastclk);
         cyc++;
         if (ack_w[0]) begin
            if (last >= 0) check_eq("b2b_ack_period", 64'(cyc - last), 64'd4);
            if (!cur_we) check_eq("b2b_rdata", 64'(rdata_w[0]), 64'hA5A5_A5A5);
            last = cyc;
            acks++;
            cur_we = ~cur_we;
            we_v[0] = cur_we;
            if (acks == 4) req_v[0] = 1'b0;
         end
      end
      req_v[0] = 1'b0;
      check_eq("b2b_ack_total", 64'(acks), 64'd4);
      ref_mem[key(0, 19'h00001)] = 32'hA5A5_A5A5;
      exp_rdata[0] = 32'hA5A5_A5A5;
      repeat (2) @(negedge fastclk);
      check_eq("b2b_idle_busy", 64'(busy_w[0]), 64'd0);
   endtask

   task automatic reset_mid_strobe();
      int acks = 0;
      @(posedge fastclk);
      #1;
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 19'h00300; wdata_v[0] = $urandom;
      @(posedge fastclk);
      #1;
      req_v[0] = 1'b0;
      for (int j = 0; j <= s_of(0); j++) @(negedge fastclk);
      check_eq("mid_pre_wr", 64'(wr[0]), 64'd0);
      rst[0] = 1'b1;
      @(posedge fastclk);
      #1;
      rst[0] = 1'b0;
      @(negedge fastclk);
      check_eq("mid_wr", 64'(wr[0]), 64'd1);
      check_eq("mid_cs", 64'(cs[0]), 64'd1);
      check_eq("mid_doe", 64'(doe[0]), 64'd0);
      check_eq("mid_busy", 64'(busy_w[0]), 64'd0);
      exp_rdata[0] = '0;
      for (int j = 0; j < 8; j++) begin
         if (ack_w[0]) acks++;
         @(negedge fastclk);
      end
      check_eq("mid_no_ack", 64'(acks), 64'd0);
   endtask

   logic [AW-1:0] pool [8];

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wdata_v[s] = '0;
         exp_rdata[s] = '0;
      end
      pool = '{19'h00000, 19'h00010, 19'h00011, 19'h01234, 19'h3FFFF, 19'h40000,
               19'h7FFFE, 19'h7FFFF};
      reset_check(0);
      reset_check(1);

      access(0, 1'b1, 19'h00010, 32'hDEAD_BEEF, 1'b0);
      check_eq("sram_0x10", 64'(g_sram[0].mem[16]), 64'hDEAD_BEEF);
      access(0, 1'b0, 19'h7FFFF, 32'h0, 1'b0);
      back_to_back();
      access(0, 1'b1, 19'h00040, 32'h0BAD_F00D, 1'b1);
      check_eq("busy_no_write_0x2", 64'(g_sram[0].wrt[2]), 64'd0);
      access(0, 1'b0, 19'h00040, 32'h0, 1'b0);
      reset_mid_strobe();

      access(1, 1'b1, 19'h00055, 32'h5555_AAAA, 1'b0);
      access(1, 1'b0, 19'h00055, 32'h0, 1'b0);
      access(1, 1'b0, 19'h7FFFF, 32'h0, 1'b1);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge fastclk);
            access(s, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom, 1'b0);
         end
      end

      check_eq("d0_strobe_overlap", 64'(g_sram[0].overlap), 64'd0);
      check_eq("d1_strobe_overlap", 64'(g_sram[1].overlap), 64'd0);
      check_eq("d0_wr_undriven", 64'(g_sram[0].nodrive), 64'd0);
      check_eq("d1_wr_undriven", 64'(g_sram[1].nodrive), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
